uart_tx: RTL

Serial UART transmitter (8N1 / 8N2) that sits directly downstream of the output buffer in the core's UART path. It accepts one byte per `sdata_valid` pulse while idle and serializes it onto `txd`: start bit, 8 data bits LSB first, then stop bit(s). It holds `tx_busy` high for the whole frame; the buffer uses this signal to throttle its byte stream.

---
 rtl/uart_tx.sv | 94 +++++++++
 1 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8N2 UART transmitter: start bit, 8 data bits LSB first, stop bit(s).
module uart_tx #(
  parameter int CLK_PER_BIT = 868,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] sdata,
  input  logic       sdata_valid,
  output logic       tx_busy,
  output logic       txd
);

  localparam int CW = (STOP_BITS * CLK_PER_BIT > 1) ? $clog2(STOP_BITS * CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLK_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          txd_n;
  logic          wrap;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      txd     <= txd_n;
      tx_busy <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    wrap      = 1'b0;
    txd_n     = 1'b1;

    case (state)
      IDLE: begin
        if (sdata_valid) begin
          state_n   = START;
          shift_n   = sdata;
          cnt_n     = '0;
          bit_idx_n = '0;
        end
      end
      START: begin
        wrap = (cnt == BIT_LAST);
        if (wrap) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        wrap = (cnt == BIT_LAST);
        if (wrap) begin
          shift_n   = {1'b0, shift[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        wrap = (cnt == STOP_LAST);
        if (wrap) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE) cnt_n = wrap ? '0 : cnt + CW'(1);

    // Line level is derived from the next state so txd comes straight off a flop.
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      default: txd_n = 1'b1;
    endcase
  end

endmodule
